// File: rtl/irq_pkg.sv
// Shared widths, state encoding and vector type for the interrupt pending/arbiter slice.
package irq_pkg;
    localparam int IRQ_N = 8;
    localparam int VEC_W = 3;

    typedef enum logic {IDLE, OFFER} irq_state_t;
    typedef logic [IRQ_N-1:0] irq_vec_t;
endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for a bus of independent asynchronous lines; every stage resets to 0.
module irq_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_reg [STAGES];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_reg[gi] <= '0;
                    else        stage_reg[gi] <= d;
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_reg[gi] <= '0;
                    else        stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/priority_encoder.sv
// 8-bit combinational priority encoder: highest set bit of a wins; none flags an all-zero input.
module priority_encoder
    import irq_pkg::*;
(
    input  logic [IRQ_N-1:0] a,
    output logic [VEC_W-1:0] y,
    output logic             none
);

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        y    = '0;
        none = 1'b1;
        for (int i = 0; i < IRQ_N; i++) begin
            if (a[i]) begin
                y    = i[VEC_W-1:0];
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/irq_pending_arbiter.sv
// Captures synchronised interrupt rising edges into a pending register and offers the
// highest-priority enabled request on a valid/ready handshake, clearing it on acceptance.
module irq_pending_arbiter
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IRQ_N-1:0] irq_i,
    input  logic [IRQ_N-1:0] mask_i,
    output logic [VEC_W-1:0] vec_o,
    output logic             vec_valid_o,
    input  logic             vec_ready_i,
    output logic [IRQ_N-1:0] pending_o,
    output logic             none_o
);

    irq_vec_t         sync_q;
    irq_vec_t         prev_reg;
    irq_vec_t         pending_reg;
    irq_vec_t         pending_next;
    irq_vec_t         rise;
    irq_vec_t         clr;
    irq_vec_t         eligible;
    logic [VEC_W-1:0] enc_y;
    logic             enc_none;
    logic [VEC_W-1:0] vec_reg;
    logic             valid_reg;
    irq_state_t       state_reg;

    irq_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (IRQ_N)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (irq_i),
        .q     (sync_q)
    );

    assign rise = sync_q & ~prev_reg;

    generate
        for (genvar gi = 0; gi < IRQ_N; gi++) begin : g_clr
            assign clr[gi] = valid_reg & vec_ready_i & (vec_reg == VEC_W'(gi));
        end
    endgenerate

    // Set dominates clear so an edge landing on the accept cycle survives.
    assign pending_next = rise | (pending_reg & ~clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg    <= '0;
            pending_reg <= '0;
        end else begin
            prev_reg    <= sync_q;
            pending_reg <= pending_next;
        end
    end

    assign eligible = pending_reg & mask_i;

    priority_encoder u_enc (
        .a    (eligible),
        .y    (enc_y),
        .none (enc_none)
    );

    // An offer, once made, is held unchanged until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            vec_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!enc_none) begin
                        vec_reg   <= enc_y;
                        valid_reg <= 1'b1;
                        state_reg <= OFFER;
                    end else begin
                        valid_reg <= 1'b0;
                    end
                end
                OFFER: begin
                    if (vec_ready_i) begin
                        valid_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign vec_o       = vec_reg;
    assign vec_valid_o = valid_reg;
    assign pending_o   = pending_reg;
    assign none_o      = enc_none;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Directed scenarios plus randomised traffic, checked every cycle against a behavioural model.
module tb_irq_pending_arbiter;

    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq;
    logic [7:0] mask;
    logic       ready;
    logic [2:0] vec;
    logic       valid;
    logic [7:0] pending;
    logic       none;

    int n_vec = 0;
    int n_err = 0;

    // Model: history of sampled irq values, pending set, and the current offer.
    logic [7:0] samp [SYNC_STAGES+1];
    logic [7:0] m_pend;
    bit         m_off;
    int         m_vec;

    always #5 clk = ~clk;

    irq_pending_arbiter #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_i       (irq),
        .mask_i      (mask),
        .vec_o       (vec),
        .vec_valid_o (valid),
        .vec_ready_i (ready),
        .pending_o   (pending),
        .none_o      (none)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k <= SYNC_STAGES; k++) samp[k] = 8'h00;
        m_pend = 8'h00;
        m_off  = 1'b0;
        m_vec  = 0;
    endtask

    // A line counts as newly raised when it was high SYNC_STAGES samples ago but not the one before.
    task automatic model_edge();
        logic [7:0] rise_m;
        logic [7:0] clr_m;
        logic [7:0] elig_m;
        rise_m = samp[SYNC_STAGES-1] & ~samp[SYNC_STAGES];
        clr_m  = 8'h00;
        if (m_off && ready) clr_m[m_vec] = 1'b1;
        elig_m = m_pend & mask;
        if (!m_off) begin
            if (elig_m != 8'h00) begin
                m_off = 1'b1;
                for (int i = 0; i < 8; i++) if (elig_m[i]) m_vec = i;
            end
        end else if (ready) begin
            m_off = 1'b0;
        end
        m_pend = rise_m | (m_pend & ~clr_m);
        for (int k = SYNC_STAGES; k > 0; k--) samp[k] = samp[k-1];
        samp[0] = irq;
    endtask

    task automatic check_all();
        chk("pending", pending, m_pend);
        chk("valid", {7'd0, valid}, {7'd0, m_off});
        chk("vec", {5'd0, vec}, {5'd0, m_vec[2:0]});
        chk("none", {7'd0, none}, {7'd0, (m_pend & mask) == 8'h00});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pending"}, pending, 8'h00);
        chk({tag, "_valid"}, {7'd0, valid}, 8'h00);
        chk({tag, "_vec"}, {5'd0, vec}, 8'h00);
        chk({tag, "_none"}, {7'd0, none}, 8'h01);
    endtask

    initial begin
        rst_n = 1'b0;
        irq   = 8'h00;
        mask  = 8'hFF;
        ready = 1'b0;
        model_reset();
        #12;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Quiet period.
        steps(20);

        // Single request on line 3, held offer, then accept.
        irq = 8'h08; step(); irq = 8'h00;
        step(); step();
        chk("t2_pending_e3", pending, 8'h08);
        step();
        chk("t2_valid_e4", {7'd0, valid}, 8'h01);
        chk("t2_vec_e4", {5'd0, vec}, 8'h03);
        steps(10);
        chk("t2_vec_held", {5'd0, vec}, 8'h03);
        ready = 1'b1; step(); ready = 1'b0;
        chk("t2_pending_clr", pending, 8'h00);
        chk("t2_valid_drop", {7'd0, valid}, 8'h00);
        steps(3);

        // Lines 1 and 6 together, consumer always ready.
        ready = 1'b1;
        irq = 8'h42; step(); irq = 8'h00;
        steps(3);
        chk("t3_first_vec", {5'd0, vec}, 8'h06);
        chk("t3_first_valid", {7'd0, valid}, 8'h01);
        step();
        chk("t3_gap", {7'd0, valid}, 8'h00);
        step();
        chk("t3_second_vec", {5'd0, vec}, 8'h01);
        chk("t3_second_valid", {7'd0, valid}, 8'h01);
        step();
        chk("t3_none", {7'd0, none}, 8'h01);
        ready = 1'b0;
        steps(3);

        // Higher-priority arrival does not replace an outstanding offer.
        irq = 8'h04; step(); irq = 8'h00;
        steps(3);
        chk("t4_offer2", {5'd0, vec}, 8'h02);
        irq = 8'h80; step(); irq = 8'h00;
        steps(4);
        chk("t4_pending", pending, 8'h84);
        chk("t4_still2", {5'd0, vec}, 8'h02);
        ready = 1'b1; step(); ready = 1'b0;
        step();
        chk("t4_next7", {5'd0, vec}, 8'h07);
        chk("t4_next_valid", {7'd0, valid}, 8'h01);
        ready = 1'b1; step(); ready = 1'b0;
        steps(3);

        // Accept line 5 on the same edge a new rise on line 5 lands.
        irq = 8'h20; step(); irq = 8'h00;
        steps(3);
        chk("t5_offer5", {5'd0, vec}, 8'h05);
        irq = 8'h20; step(); irq = 8'h00;
        step();
        ready = 1'b1; step(); ready = 1'b0;
        chk("t5_pending_kept", pending, 8'h20);
        chk("t5_gap", {7'd0, valid}, 8'h00);
        step();
        chk("t5_reoffer", {5'd0, vec}, 8'h05);
        chk("t5_reoffer_valid", {7'd0, valid}, 8'h01);
        ready = 1'b1; step(); ready = 1'b0;
        steps(3);

        // Masked request is retained and served once unmasked.
        mask = 8'h0F;
        irq = 8'h10; step(); irq = 8'h00;
        steps(5);
        chk("t6_pending", pending, 8'h10);
        chk("t6_none", {7'd0, none}, 8'h01);
        chk("t6_no_offer", {7'd0, valid}, 8'h00);
        mask = 8'hFF;
        step();
        chk("t6_offer4", {5'd0, vec}, 8'h04);
        chk("t6_offer_valid", {7'd0, valid}, 8'h01);

        // Reset while offering aborts everything at once.
        irq = 8'h01; step(); irq = 8'h00;
        rst_n = 1'b0;
        #1;
        check_reset_values("t6_async_rst");
        model_reset();
        #3 rst_n = 1'b1;
        steps(6);

        // Randomised traffic.
        for (int c = 0; c < 800; c++) begin
            irq   = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 40) == 0) mask = 8'($urandom);
            if (c == 400) begin
                rst_n = 1'b0;
                #1;
                check_reset_values("rand_rst");
                model_reset();
                #3 rst_n = 1'b1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
